// File: rtl/pixel_array_sequencer.sv
// pixel_array_sequencer: per-frame ERASE/EXPOSE/CONVERT/READ sequencer for pixelArray with a valid/ready pixel stream.
module pixel_array_sequencer #(
  parameter int N_PIX     = 2,
  parameter int READ_W    = 4,
  parameter int NUM_GRP   = 2,
  parameter int RD_SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cont,
  input  logic [7:0]           cfg_erase,
  input  logic [15:0]          cfg_expose,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 erase,
  output logic                 expose,
  output logic                 ramp_en,
  output logic [READ_W-1:0]    read,
  output logic                 bus_oe,
  output logic [N_PIX*8-1:0]   dac_code,
  input  logic [N_PIX*8-1:0]   pix_data,
  output logic [N_PIX*8-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);
  localparam int GW = READ_W / NUM_GRP;
  localparam int GRPW = NUM_GRP > 1 ? $clog2(NUM_GRP) : 1;
  localparam logic [GRPW-1:0] LAST_GRP = GRPW'(NUM_GRP - 1);
  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, GAP} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [15:0] x_len;
  logic [7:0] e_len;
  logic [7:0] dac;
  logic [GRPW-1:0] grp;
  logic [7:0] e_in;
  logic [15:0] x_in;
  logic last;
  assign e_in = cfg_erase == 8'd0 ? 8'd1 : cfg_erase;
  assign x_in = cfg_expose == 16'd0 ? 16'd1 : cfg_expose;
  assign last = grp == LAST_GRP;
  assign dac_code = {N_PIX{dac}};
  // Group 0 owns the top GW bits of READ, later groups walk downward.
  function automatic logic [READ_W-1:0] grp_mask(input int g);
    logic [READ_W-1:0] m;
    for (int i = 0; i < READ_W; i++) m[i] = (i >= READ_W - (g + 1) * GW) && (i < READ_W - g * GW);
    return m;
  endfunction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      e_len <= '0;
      x_len <= '0;
      dac <= '0;
      grp <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      erase <= 1'b0;
      expose <= 1'b0;
      ramp_en <= 1'b0;
      read <= '0;
      bus_oe <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ERASE;
          busy <= 1'b1;
          erase <= 1'b1;
          e_len <= e_in;
          x_len <= x_in;
          cnt <= '0;
        end
        ERASE: if (cnt == {8'd0, e_len} - 16'd1) begin
          state <= EXPOSE;
          erase <= 1'b0;
          expose <= 1'b1;
          cnt <= '0;
        end else cnt <= cnt + 16'd1;
        EXPOSE: if (cnt == x_len - 16'd1) begin
          state <= CONVERT;
          expose <= 1'b0;
          ramp_en <= 1'b1;
          bus_oe <= 1'b1;
          dac <= '0;
        end else cnt <= cnt + 16'd1;
        CONVERT: if (dac == 8'hff) begin
          state <= READ;
          ramp_en <= 1'b0;
          bus_oe <= 1'b0;
          dac <= '0;
          grp <= '0;
          read <= grp_mask(0);
          cnt <= '0;
        end else dac <= dac + 8'd1;
        READ: if (out_valid) begin
          if (out_ready) begin
            state <= GAP;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            read <= '0;
            frame_done <= last;
          end
        end else if (cnt == 16'(RD_SETTLE - 1)) begin
          out_valid <= 1'b1;
          out_data <= pix_data;
          out_last <= last;
        end else cnt <= cnt + 16'd1;
        GAP: if (!last) begin
          state <= READ;
          grp <= grp + 1'b1;
          read <= grp_mask(int'(grp) + 1);
          cnt <= '0;
        end else if (cont) begin
          state <= ERASE;
          erase <= 1'b1;
          e_len <= e_in;
          x_len <= x_in;
          cnt <= '0;
        end else begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_array_sequencer.sv
// tb_pixel_array_sequencer: directed frame scenarios against hand-computed counts, words and latencies.
module tb_pixel_array_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic [7:0] cfg_erase = '0;
  logic [15:0] cfg_expose = '0;
  logic busy, frame_done, erase, expose, ramp_en, bus_oe, out_valid, out_last;
  logic out_ready = 1'b1;
  logic [3:0] read;
  logic [15:0] dac_code, pix_data, out_data;
  logic [15:0] noise = '0;
  int checks = 0;
  int errors = 0;
  int n_erase, n_expose, n_ramp, n_done, dac_bad, viol, gap_erase;
  logic prev_done;
  logic [7:0] exp_dac;
  logic [20:0] words[$];

  always #5 clk = ~clk;

  assign pix_data = (read == 4'b1100 ? 16'hA1B2 : read == 4'b0011 ? 16'hC3D4 : 16'h0000) ^ noise;

  pixel_array_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont),
    .cfg_erase(cfg_erase), .cfg_expose(cfg_expose),
    .busy(busy), .frame_done(frame_done), .erase(erase), .expose(expose),
    .ramp_en(ramp_en), .read(read), .bus_oe(bus_oe), .dac_code(dac_code),
    .pix_data(pix_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always @(negedge clk) begin
    if (erase) n_erase++;
    if (expose) n_expose++;
    if (frame_done) n_done++;
    if (prev_done && erase) gap_erase++;
    prev_done = frame_done;
    if (ramp_en) begin
      if (dac_code !== {2{exp_dac}}) dac_bad++;
      exp_dac++;
      n_ramp++;
    end else exp_dac = 8'd0;
    if (bus_oe && read != 4'd0) viol++;
    if (32'(erase) + 32'(expose) + 32'(ramp_en) > 1) viol++;
    if (frame_done && read != 4'd0) viol++;
    if (out_valid && out_ready) words.push_back({read, out_last, out_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_erase = 0; n_expose = 0; n_ramp = 0; n_done = 0;
    dac_bad = 0; viol = 0; gap_erase = 0; prev_done = 1'b0;
    words.delete();
  endtask

  task automatic pulse_start(input logic [7:0] e, input logic [15:0] x);
    cfg_erase = e;
    cfg_expose = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int lat);
    bit done = 0;
    lat = 0;
    for (int k = 1; k < 70000; k++) begin
      if (out_valid && lat == 0) lat = k;
      if (!busy) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    check("idle_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_valid();
    bit done = 0;
    for (int k = 0; k < 2000; k++) begin
      if (out_valid) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    check("valid_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_words(input string tag);
    check({tag, "_nwords"}, 32'(words.size()), 32'd2);
    if (words.size() == 2) begin
      check({tag, "_w0"}, 32'(words[0]), {11'd0, 4'hC, 1'b0, 16'hA1B2});
      check({tag, "_w1"}, 32'(words[1]), {11'd0, 4'h3, 1'b1, 16'hC3D4});
    end
  endtask

  initial begin
    int lat, drops, seen, stall_bad;
    bit ok;
    clear_mon();
    exp_dac = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, frame_done, erase, expose, ramp_en, read, bus_oe, out_valid, out_last},
          32'd0);
    check("reset_dac", 32'(dac_code), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    clear_mon();
    pulse_start(8'd5, 16'd255);
    wait_idle(lat);
    check("t1_erase", n_erase, 5);
    check("t1_expose", n_expose, 255);
    check("t1_ramp", n_ramp, 256);
    check("t1_dac", dac_bad, 0);
    check("t1_done", n_done, 1);
    check("t1_lat", lat, 1 + 5 + 255 + 256 + 2);
    check("t1_viol", viol, 0);
    check_words("t1");

    @(negedge clk);
    clear_mon();
    pulse_start(8'd0, 16'd0);
    wait_idle(lat);
    check("t2_erase", n_erase, 1);
    check("t2_expose", n_expose, 1);
    check("t2_lat", lat, 1 + 1 + 1 + 256 + 2);
    check_words("t2");

    @(negedge clk);
    clear_mon();
    out_ready = 1'b0;
    pulse_start(8'd2, 16'd3);
    wait_valid();
    noise = 16'hFFFF;
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (read !== 4'b1100 || out_data !== 16'hA1B2 || !out_valid) stall_bad++;
      @(negedge clk);
    end
    check("t3_stall", stall_bad, 0);
    noise = 16'h0000;
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_gap_read", 32'(read), 32'd0);
    check("t3_gap_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t3_next_read", 32'(read), 32'h3);
    wait_idle(lat);
    check_words("t3");
    check("t3_viol", viol, 0);

    @(negedge clk);
    clear_mon();
    cont = 1'b1;
    pulse_start(8'd3, 16'd4);
    drops = 0;
    seen = 0;
    ok = 0;
    for (int k = 0; k < 5000; k++) begin
      if (!busy) drops++;
      if (frame_done) seen++;
      if (seen == 2) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("t4_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    check("t4_reerase", 32'(erase), 32'd1);
    cont = 1'b0;
    wait_idle(lat);
    check("t4_drops", drops, 0);
    check("t4_done", n_done, 3);
    check("t4_erase", n_erase, 9);
    check("t4_gap_erase", gap_erase, 2);
    check("t4_nwords", 32'(words.size()), 32'd6);
    check("t4_viol", viol, 0);

    @(negedge clk);
    clear_mon();
    pulse_start(8'd1, 16'd1);
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      if (ramp_en && dac_code[7:0] == 8'd100) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("t5_timeout", 32'(ok), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_outs", {busy, frame_done, erase, expose, ramp_en, read, bus_oe, out_valid, out_last},
          32'd0);
    check("t5_async_dac", 32'(dac_code), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_mon();
    pulse_start(8'd1, 16'd1);
    wait_idle(lat);
    check("t5_ramp", n_ramp, 256);
    check("t5_dac", dac_bad, 0);
    check("t5_done", n_done, 1);
    check_words("t5");

    @(negedge clk);
    clear_mon();
    pulse_start(8'd2, 16'd20);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (expose) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("t6_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(lat);
    repeat (20) @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", n_done, 1);
    check("t6_erase", n_erase, 2);
    check_words("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
